// File: rtl/pio_regs_pkg.sv
// pio_regs_pkg: register offsets and bit positions shared by PIO blocks.
package pio_regs_pkg;
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_PERIOD   = 3'd6;
    localparam logic [2:0] ADDR_STATUS   = 3'd7;
    localparam int         STATUS_PHASE_BIT = 0;
endpackage

// File: rtl/pio_blink_timer.sv
// pio_blink_timer: half-period counter that toggles phase every period clocks.
module pio_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    output logic             phase
);
    logic [CNT_W-1:0] r_cnt;
    logic             r_phase;
    logic             w_wrap;

    assign w_wrap = r_cnt == period - CNT_W'(1);
    assign phase  = r_phase;

    // A period write restarts the half-period and overrides a coincident wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (period_wr || period == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pio_led_blink.sv
// pio_led_blink: Avalon-MM output port with set/clear strobes and per-bit blink gating.
module pio_led_blink #(
    parameter int               WIDTH       = 18,
    parameter int               CNT_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    import pio_regs_pkg::*;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_blink_en;
    logic [CNT_W-1:0] r_period;
    logic [WIDTH-1:0] w_wd;
    logic             w_wr;
    logic             w_period_wr;
    logic             w_phase;
    logic             w_unused_wd;

    assign w_wr        = chipselect && !write_n;
    assign w_period_wr = w_wr && address == ADDR_PERIOD;
    assign w_wd        = writedata[WIDTH-1:0];
    assign w_unused_wd = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_period   <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:     r_data     <= w_wd;
                ADDR_BLINK_EN: r_blink_en <= w_wd;
                ADDR_OUTSET:   r_data     <= r_data | w_wd;
                ADDR_OUTCLEAR: r_data     <= r_data & ~w_wd;
                ADDR_PERIOD:   r_period   <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    pio_blink_timer #(.CNT_W(CNT_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .period    (r_period),
        .period_wr (w_period_wr),
        .phase     (w_phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(r_data);
            ADDR_BLINK_EN: readdata = 32'(r_blink_en);
            ADDR_PERIOD:   readdata = 32'(r_period);
            ADDR_STATUS:   readdata[STATUS_PHASE_BIT] = w_phase;
            default: ;
        endcase
    end

    // Blinking bits are forced low during phase 0; steady bits pass DATA.
    assign out_port = r_data & (~r_blink_en | {WIDTH{w_phase}});
endmodule

// File: tb/tb_pio_led_blink.sv
// tb_pio_led_blink: table vectors, corner sequences and random traffic against a timing model.
module tb_pio_led_blink;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata8;
    logic [17:0] out_port;
    logic [7:0]  out_port8;

    int vectors = 0;
    int miscompares = 0;

    logic [17:0] m_data;
    logic [17:0] m_blink;
    logic [23:0] m_period;
    int          m_k;

    always #5 clk = ~clk;

    pio_led_blink #(.WIDTH(18), .CNT_W(24), .RESET_VALUE(18'h00F0F)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    pio_led_blink #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata8), .out_port(out_port8)
    );

    // Phase follows from the number of edges since the last period restart.
    function automatic logic m_phase();
        return (m_period == 0) ? 1'b1 : (((m_k / int'(m_period)) % 2) == 0);
    endfunction

    function automatic logic [17:0] m_out();
        return m_data & (~m_blink | {18{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {14'd0, m_data};
            3'd1: return {14'd0, m_blink};
            3'd6: return {8'd0, m_period};
            3'd7: return {31'd0, m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data = 18'h00F0F; m_blink = '0; m_period = '0; m_k = 0;
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) begin
            m_k++;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[17:0];
                    3'd1: m_blink = writedata[17:0];
                    3'd4: m_data = m_data | writedata[17:0];
                    3'd5: m_data = m_data & ~writedata[17:0];
                    3'd6: begin m_period = writedata[23:0]; m_k = 0; end
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic rd_chk(input string name, input logic [2:0] a);
        address = a;
        #1;
        chk(name, readdata, m_read(a));
        chk({name, "_out"}, {14'd0, out_port}, {14'd0, m_out()});
    endtask

    typedef struct {
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp_rd;
        logic [17:0] exp_out;
    } vec_t;

    vec_t tbl[11];
    logic [31:0] rst_exp[8];

    initial begin
        tbl[0]  = '{3'd0, 32'h0003FFFF, 3'd0, 32'h0003FFFF, 18'h3FFFF};
        tbl[1]  = '{3'd5, 32'h00000003, 3'd0, 32'h0003FFFC, 18'h3FFFC};
        tbl[2]  = '{3'd4, 32'h00000001, 3'd0, 32'h0003FFFD, 18'h3FFFD};
        tbl[3]  = '{3'd2, 32'hFFFFFFFF, 3'd0, 32'h0003FFFD, 18'h3FFFD};
        tbl[4]  = '{3'd3, 32'h00012345, 3'd1, 32'h00000000, 18'h3FFFD};
        tbl[5]  = '{3'd4, 32'hFFFC0000, 3'd0, 32'h0003FFFD, 18'h3FFFD};
        tbl[6]  = '{3'd1, 32'hFFFFFFFF, 3'd1, 32'h0003FFFF, 18'h3FFFD};
        tbl[7]  = '{3'd1, 32'h00000000, 3'd4, 32'h00000000, 18'h3FFFD};
        tbl[8]  = '{3'd6, 32'hFF000007, 3'd6, 32'h00000007, 18'h3FFFD};
        tbl[9]  = '{3'd6, 32'h00000000, 3'd5, 32'h00000000, 18'h3FFFD};
        tbl[10] = '{3'd2, 32'h0000FFFF, 3'd7, 32'h00000001, 18'h3FFFD};
        rst_exp = '{32'h00000F0F, 0, 0, 0, 0, 0, 0, 32'h00000001};
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", {14'd0, out_port}, 32'h00000F0F);
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            chk($sformatf("rst_rd%0d", i), readdata, rst_exp[i]);
        end
        reset = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].wa, tbl[i].wd);
            address = tbl[i].ra;
            #1;
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_out", i), {14'd0, out_port}, {14'd0, tbl[i].exp_out});
            chk($sformatf("tbl%0d_model", i), readdata, m_read(tbl[i].ra));
        end
        wr(3'd0, 32'hFFFFFFFF);
        address = 3'd0;
        #1;
        chk("w8_rd", readdata8, 32'h000000FF);
        chk("w8_out", {24'd0, out_port8}, 32'h000000FF);
        wr(3'd0, 32'h0003FFFF);
        wr(3'd1, 32'h00000001);
        wr(3'd6, 32'h00000004);
        address = 3'd7;
        for (int i = 0; i < 24; i++) begin
            #1;
            chk($sformatf("blink%0d", i), {31'd0, out_port[0]}, {31'd0, ((i / 4) % 2) == 0});
            chk($sformatf("blink_hi%0d", i), {15'd0, out_port[17:1]}, {15'd0, 17'h1FFFF});
            chk($sformatf("blink_st%0d", i), readdata, {31'd0, out_port[0]});
            step();
        end
        wr(3'd6, 32'h00000003);
        step();
        step();
        wr(3'd6, 32'h00000005);
        address = 3'd7;
        #1;
        chk("coll_wr", readdata, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("coll%0d", i), readdata, (i < 5) ? 32'h1 : 32'h0);
        end
        wr(3'd0, 32'h0003FFFF);
        wr(3'd1, 32'h00000001);
        wr(3'd6, 32'h00000002);
        step();
        step();
        address = 3'd6;
        #1;
        chk("mid_pre", {31'd0, out_port[0]}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_out", {14'd0, out_port}, 32'h00000F0F);
        chk("mid_period", readdata, 32'h0);
        m_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        address = 3'd7;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("post%0d_out", i), {14'd0, out_port}, 32'h00000F0F);
            chk($sformatf("post%0d_st", i), readdata, 32'h1);
        end
        for (int i = 0; i < 300; i++) begin
            logic [2:0]  a;
            logic [31:0] d;
            a = 3'($urandom_range(0, 7));
            d = $urandom;
            if (a == 3'd6) d = {d[31:24], 21'd0, 3'($urandom_range(0, 6))};
            address = a;
            writedata = d;
            chipselect = ($urandom % 4) != 0;
            write_n = ($urandom % 3) == 0;
            step();
            chipselect = 1'b0;
            write_n = 1'b1;
            rd_chk($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)));
            if ($urandom % 2 == 1) begin
                step();
                rd_chk($sformatf("rnd%0d_idle", i), 3'd7);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
